// File: rtl/gate_bist_ctrl_if.sv
// Handshake and result bundle between the gate BIST controller and its host.
// Optional resp_vec member appears only when GATE_BIST_RESP_EN is defined.
interface gate_bist_ctrl_if;
  logic       start;
  logic       dut_y;
  logic [2:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;
`ifdef GATE_BIST_RESP_EN
  logic [7:0] resp_vec;
`endif

  modport slave (
    input  start, dut_y,
    output dut_in, busy, done, pass, err_cnt, fail_vec
`ifdef GATE_BIST_RESP_EN
    , output resp_vec
`endif
  );

  modport master (
    output start, dut_y,
    input  dut_in, busy, done, pass, err_cnt, fail_vec
`ifdef GATE_BIST_RESP_EN
    , input resp_vec
`endif
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive 3-input truth-table BIST for a switch-level gate under test.
// Define GATE_BIST_RESP_EN to add the per-vector response capture (resp_vec).
module gate_bist_ctrl #(
  parameter int         SETTLE = 2,
  parameter logic [7:0] EXP_TT = 8'h7F
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_bist_ctrl_if.slave  bus
);

  localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW    = (S_EFF < 2) ? 1 : $clog2(S_EFF);
  localparam logic [CW-1:0] CNT_LAST = CW'(S_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [2:0]    dut_in_r, dut_in_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic [3:0]    err_cnt_r, err_cnt_s;
  logic [2:0]    fail_vec_r, fail_vec_s;
  logic          first_fail_r, first_fail_s;
  logic [7:0]    resp_r, resp_s;
  logic          mismatch_s;

  // Next-state and next-register values for the whole controller.
  always_comb begin
    state_s      = state_r;
    dut_in_s     = dut_in_r;
    cnt_s        = cnt_r;
    busy_s       = busy_r;
    done_s       = done_r;
    pass_s       = pass_r;
    err_cnt_s    = err_cnt_r;
    fail_vec_s   = fail_vec_r;
    first_fail_s = first_fail_r;
    resp_s       = resp_r;
    // Case inequality so an X/Z response is scored as a mismatch.
    mismatch_s   = (bus.dut_y !== EXP_TT[dut_in_r]);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_s      = ST_SETTLE;
          dut_in_s     = 3'd0;
          cnt_s        = '0;
          busy_s       = 1'b1;
          done_s       = 1'b0;
          pass_s       = 1'b0;
          err_cnt_s    = 4'd0;
          fail_vec_s   = 3'd0;
          first_fail_s = 1'b0;
          resp_s       = 8'h00;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        cnt_s = cnt_r + 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        resp_s[dut_in_r] = bus.dut_y;
        if (mismatch_s) begin
          err_cnt_s = err_cnt_r + 4'd1;
          if (!first_fail_r) begin
            fail_vec_s   = dut_in_r;
            first_fail_s = 1'b1;
          end else begin
            fail_vec_s   = fail_vec_r;
          end
        end else begin
          err_cnt_s = err_cnt_r;
        end
        if (dut_in_r == 3'd7) begin
          state_s  = ST_DONE;
          dut_in_s = 3'd0;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          pass_s   = (err_cnt_r == 4'd0) && !mismatch_s;
        end else begin
          state_s  = ST_SETTLE;
          dut_in_s = dut_in_r + 3'd1;
          cnt_s    = '0;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Register all state; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      dut_in_r     <= 3'd0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= 4'd0;
      fail_vec_r   <= 3'd0;
      first_fail_r <= 1'b0;
      resp_r       <= 8'h00;
    end else begin
      state_r      <= state_s;
      dut_in_r     <= dut_in_s;
      cnt_r        <= cnt_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_cnt_r    <= err_cnt_s;
      fail_vec_r   <= fail_vec_s;
      first_fail_r <= first_fail_s;
      resp_r       <= resp_s;
    end
  end

  assign bus.dut_in   = dut_in_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.err_cnt  = err_cnt_r;
  assign bus.fail_vec = fail_vec_r;
`ifdef GATE_BIST_RESP_EN
  assign bus.resp_vec = resp_r;
`else
  logic resp_unused_s;
  assign resp_unused_s = ^resp_r;
`endif

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2: wait cycles between driving a vector and sampling dut_y; any value below 1 SHALL behave as 1.
REQ-002 SHALL have parameter EXP_TT, default 8'h7F: expected truth table, where bit i is the expected dut_y for dut_in==i (3-input NAND).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  run request, sampled in IDLE or DONE only.
REQ-006 dut_y  input  1  output of the switch-level gate under test.
REQ-007 dut_in  output  3  stimulus vector to the gate under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until the next accepted start or reset.
REQ-010 pass  output  1  high when done is high and err_cnt==0; otherwise low.
REQ-011 err_cnt  output  4  number of mismatching vectors in the current or last run (0..8).
REQ-012 fail_vec  output  3  first mismatching vector; 0 if none.

Function
REQ-013 SHALL implement an FSM with states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 IDLE/DONE with start=1 SHALL, on the next edge, clear err_cnt, fail_vec and the first-fail flag, and set dut_in=0, settle counter=0, busy=1 and done=0, then enter SETTLE.
REQ-015 SETTLE SHALL hold dut_in stable, increment the settle counter, and move to SAMPLE after exactly SETTLE cycles.
REQ-016 SAMPLE (one cycle) SHALL compare dut_y against EXP_TT[dut_in]; any inequality, including X/Z in simulation, SHALL count as a mismatch.
REQ-017 On a mismatch, SHALL increment err_cnt; on the first mismatch of a run, SHALL also load fail_vec with dut_in.
REQ-018 From SAMPLE with dut_in!=7, SHALL increment dut_in, clear the settle counter and return to SETTLE.
REQ-019 From SAMPLE with dut_in==7, SHALL set dut_in=0, busy=0 and done=1 and enter DONE; dut_in SHALL NOT wrap to 0 through another vector cycle.
REQ-020 Latency SHALL be exactly 8*(SETTLE+1) cycles from the start-accept edge to the edge where done rises (24 cycles at SETTLE=2).
REQ-021 start while busy SHALL be ignored, with no restart and no counter disturbance.
REQ-022 err_cnt SHALL reach at most 8; a 4-bit width SHALL suffice, with no wrap.
REQ-023 dut_in SHALL be 3'b000 in IDLE and DONE.
REQ-024 Outputs SHALL be registered; no combinational path from dut_y to any output.

Reset
REQ-025 On rst_n=0 at a clock edge, SHALL enter IDLE with dut_in=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, settle counter=0.
REQ-026 Reset mid-run SHALL abort the run immediately with no done pulse; partial results SHALL be discarded.
REQ-027 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-028 Macro GATE_BIST_RESP_EN defined: SHALL add output resp_vec[7:0]; bit i holds the dut_y sampled for vector i, resp_vec is cleared on start-accept and reset, and it is valid when done=1.
REQ-029 Macro GATE_BIST_RESP_EN undefined: resp_vec port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Good NAND3, SETTLE=2, start pulse -> done rises 24 cycles after accept; pass=1, err_cnt=0, fail_vec=0; resp_vec=8'h7F if enabled.
REQ-031 dut_y stuck at 1 -> err_cnt=1, fail_vec=3'd7, pass=0.
REQ-032 dut_y stuck at 0 -> err_cnt=7, fail_vec=3'd0, pass=0.
REQ-033 rst_n=0 while SETTLE is on vector 4 -> next cycle IDLE with all outputs 0; a later start gives a full 8-vector run.
REQ-034 start held high for the whole run, then restart from DONE -> no restart while busy; second accept clears err_cnt and done next edge.
REQ-035 EXP_TT=8'hFE, SETTLE=0 with OR3-model DUT -> behaves as SETTLE=1, done 16 cycles after accept, pass=1.
